reg_dump_scanner: RTL and testbench
===================================

REG_DUMP_SCANNER -- requirements
Module: reg_dump_scanner

Interface
REQ-001 Parameter HALT_PC, 32'hF0000100, PC value that ends the run.
REQ-002 Parameter MAX_CYCLES, 1000, watchdog limit in run cycles.
REQ-003 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  in  1  reset, synchronous and active-high.
REQ-005 Port pc  in  32  current CPU program counter.
REQ-006 Port cpu_hold  out  1  freezes CPU state while high.
REQ-007 Port reg_sel  out  5  register-file debug read index.
REQ-008 Port reg_data  in  32  register-file read data, valid combinationally in the same cycle as reg_sel.
REQ-009 Port out_valid  out  1  dump beat valid.
REQ-010 Port out_ready  in  1  sink accepts the beat.
REQ-011 Port out_data  out  32  captured register value.
REQ-012 Port out_idx  out  5  register index of the current beat.
REQ-013 Port done  out  1  dump complete.
REQ-014 Port halt_cause  out  2  00 none, 01 halt PC, 10 watchdog.

Function
REQ-015 The FSM SHALL have exactly four states: RUN, SEL, SEND and DONE.
REQ-016 In RUN, the 32-bit cycle_cnt SHALL increment by one every cycle, starting at 0 in the first cycle after reset.
REQ-017 Halt trigger: in RUN, pc==HALT_PC SHALL set halt_cause=01 and move to SEL at the next edge.
REQ-018 Watchdog trigger: in RUN, cycle_cnt==MAX_CYCLES with no PC match SHALL set halt_cause=10 and move to SEL.
REQ-019 Simultaneous PC match and watchdog SHALL resolve to halt_cause=01.
REQ-020 MAX_CYCLES=0 SHALL trigger the watchdog in the first RUN cycle.
REQ-021 cpu_hold SHALL be combinational and high when state!=RUN or a trigger condition is true in the current cycle, so the CPU never steps past the trigger cycle.
REQ-022 reg_sel SHALL be 0 in RUN and DONE and SHALL equal the dump index idx in SEL and SEND.
REQ-023 In SEL, reg_data SHALL be registered into out_data and out_idx<=idx, and the FSM SHALL move to SEND.
REQ-024 out_valid SHALL be high only in SEND.
REQ-025 In SEND, out_data and out_idx SHALL hold stable while out_ready is low.
REQ-026 A beat SHALL transfer on the edge where out_valid and out_ready are both high.
REQ-027 On transfer with idx<31, idx SHALL increment and the FSM SHALL return to SEL, giving a minimum of 2 cycles per beat.
REQ-028 On transfer with idx==31, the FSM SHALL go to DONE, with no idx wrap and no extra beat.
REQ-029 Register 0 SHALL be emitted as read from reg_data, with no forcing to zero.
REQ-030 Exactly 32 beats SHALL be emitted per dump, with indices 0..31 in order and no duplicates or gaps.
REQ-031 DONE SHALL be absorbing: done=1, cpu_hold=1, out_valid=0, and halt_cause held until rst.
REQ-032 pc and out_ready SHALL be ignored outside RUN and SEND respectively.
REQ-033 halt_cause SHALL change only on the trigger edge and on reset.

Reset
REQ-034 rst high at an edge SHALL set, in any state including mid-dump, state=RUN, cycle_cnt=0, idx=0, out_data=0, out_idx=0, halt_cause=00.
REQ-035 On the cycle after a reset edge, out_valid=0, done=0, and cpu_hold=0 unless a trigger is immediately true.
REQ-036 rst SHALL take priority over every trigger and handshake in the same cycle.
REQ-037 After reset, a new dump SHALL restart from idx 0.

Verification
REQ-038 Halt-PC dump: pc=HALT_PC at run cycle 10, out_ready=1 -> cpu_hold high in cycle 10; beats idx 0..31 match the reg-file model; done after 64 cycles; halt_cause=01.
REQ-039 Watchdog dump: pc never matches, MAX_CYCLES=1000 -> trigger exactly when cycle_cnt==1000; halt_cause=10; 32 beats then done.
REQ-040 Backpressure: out_ready high 1 cycle in 3 -> out_data/out_idx stable during stalls; 32 unique in-order beats; no loss.
REQ-041 Simultaneous trigger: pc=HALT_PC in the cycle cycle_cnt==MAX_CYCLES -> halt_cause=01.
REQ-042 Reset mid-dump: rst at idx 12 -> next cycle RUN, out_valid=0, done=0, halt_cause=00, cycle_cnt=0; re-trigger starts at idx 0.
REQ-043 DONE hold: after done, toggle pc/out_ready for 50 cycles -> no beats, done and cpu_hold remain 1.

Source files
------------

// File: rtl/reg_dump_scanner.sv
// reg_dump_scanner: freezes the CPU on a halt PC or watchdog and streams out all 32 registers
module reg_dump_scanner #(
  parameter logic [31:0] HALT_PC    = 32'hF000_0100,
  parameter logic [31:0] MAX_CYCLES = 32'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        cpu_hold,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_idx,
  output logic        done,
  output logic [1:0]  halt_cause
);
  typedef enum logic [1:0] {RUN, SEL, SEND, DONE} state_t;
  state_t      state;
  logic [31:0] cycle_cnt;
  logic [4:0]  idx;
  logic        pc_hit;
  logic        wd_hit;
  logic        trig;
  always_comb begin
    pc_hit    = state == RUN && pc == HALT_PC;
    wd_hit    = state == RUN && cycle_cnt == MAX_CYCLES;
    trig      = pc_hit || wd_hit;
    cpu_hold  = state != RUN || trig;
    reg_sel   = (state == SEL || state == SEND) ? idx : 5'd0;
    out_valid = state == SEND;
    done      = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      cycle_cnt  <= '0;
      idx        <= '0;
      out_data   <= '0;
      out_idx    <= '0;
      halt_cause <= 2'b00;
    end else begin
      case (state)
        RUN: begin
          cycle_cnt <= cycle_cnt + 32'd1;
          if (trig) begin
            halt_cause <= pc_hit ? 2'b01 : 2'b10;
            state      <= SEL;
          end
        end
        SEL: begin
          out_data <= reg_data;
          out_idx  <= idx;
          state    <= SEND;
        end
        SEND: if (out_ready) begin
          if (idx == 5'd31) state <= DONE;
          else begin
            idx   <= idx + 5'd1;
            state <= SEL;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_dump_scanner.sv
// tb_reg_dump_scanner: table-driven and randomized dump scenarios checked against a register-file model
module tb_reg_dump_scanner;
  localparam logic [31:0] HALT_PC = 32'hF000_0100;
  localparam int          MAXC    = 1000;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'h1;
  logic        out_ready = 1'b0;
  logic        cpu_hold, out_valid, done;
  logic [4:0]  reg_sel, out_idx;
  logic [31:0] reg_data, out_data;
  logic [1:0]  halt_cause;
  logic        cpu_hold0, out_valid0, done0;
  logic [4:0]  reg_sel0, out_idx0;
  logic [31:0] reg_data0, out_data0;
  logic [1:0]  halt_cause0;
  logic [31:0] regfile [32];
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {
    int       pc_cyc;
    int       rdy_mode;
    int       abort;
    int       exp_trig;
    logic [1:0] exp_cause;
    logic [1:0] exp_cause0;
    int       exp_dump;
  } vec_t;
  vec_t vecs [9];
  always #5 clk = ~clk;
  assign reg_data  = regfile[reg_sel];
  assign reg_data0 = regfile[reg_sel0];
  reg_dump_scanner #(.HALT_PC(HALT_PC), .MAX_CYCLES(32'd1000)) u_dut (
    .clk(clk), .rst(rst), .pc(pc), .cpu_hold(cpu_hold), .reg_sel(reg_sel),
    .reg_data(reg_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .done(done), .halt_cause(halt_cause)
  );
  reg_dump_scanner #(.HALT_PC(HALT_PC), .MAX_CYCLES(32'd0)) u_dut0 (
    .clk(clk), .rst(rst), .pc(pc), .cpu_hold(cpu_hold0), .reg_sel(reg_sel0),
    .reg_data(reg_data0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_idx(out_idx0), .done(done0), .halt_cause(halt_cause0)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic run(input vec_t v);
    int k, trig, nb, dc;
    logic stalled;
    logic [31:0] s_data;
    logic [4:0] s_idx;
    for (int i = 0; i < 32; i++) regfile[i] = $urandom;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pc = $urandom | 32'h1;
    #1;
    chk("rst_state", {out_valid, done, cpu_hold, halt_cause}, 5'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_idx", {27'd0, out_idx}, 32'h0);
    chk("wd0_hold", {31'd0, cpu_hold0}, 32'h1);
    k = 0;
    trig = -1;
    while (k <= MAXC + 100) begin
      pc = (k == v.pc_cyc) ? HALT_PC : ($urandom | 32'h1);
      out_ready = 1'($urandom);
      #1;
      if (cpu_hold) begin
        trig = k;
        break;
      end
      @(negedge clk);
      k++;
    end
    chk("trig_cycle", trig, v.exp_trig);
    nb = 0;
    dc = 0;
    stalled = 1'b0;
    s_data = '0;
    s_idx = '0;
    while (1) begin
      @(negedge clk);
      dc++;
      out_ready = v.rdy_mode == 0 ? 1'b1 : v.rdy_mode == 3 ? (dc % 3 == 2) : 1'($urandom);
      pc = (dc % 2 == 0) ? HALT_PC : $urandom;
      #1;
      if (dc == 1) begin
        chk("halt_cause", {30'd0, halt_cause}, {30'd0, v.exp_cause});
        chk("halt_cause_wd0", {30'd0, halt_cause0}, {30'd0, v.exp_cause0});
      end
      if (done) break;
      if (stalled) begin
        chk("stall_valid", {31'd0, out_valid}, 32'h1);
        chk("stall_data", out_data, s_data);
        chk("stall_idx", {27'd0, out_idx}, {27'd0, s_idx});
      end
      if (v.abort >= 0 && out_valid && out_idx == 5'(v.abort)) begin
        chk("abort_beats", nb, v.abort);
        return;
      end
      if (out_valid && out_ready) begin
        if (nb >= 32) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_beat: got beat %0d idx %0d expected none", nb, out_idx);
        end else begin
          chk("beat_idx", {27'd0, out_idx}, nb);
          chk("beat_data", out_data, regfile[nb]);
        end
        nb++;
      end
      stalled = out_valid && !out_ready;
      s_data = out_data;
      s_idx = out_idx;
      if (dc > 600) begin
        n_cmp++;
        n_err++;
        $display("FAIL dump_timeout: got no done after %0d cycles expected done", dc);
        break;
      end
    end
    chk("beat_count", nb, 32);
    if (v.exp_dump >= 0) chk("dump_cycles", dc - 1, v.exp_dump);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      pc = (i % 2 == 0) ? HALT_PC : $urandom;
      out_ready = 1'($urandom);
      #1;
      chk("done_hold", {27'd0, done, cpu_hold, out_valid, halt_cause}, {27'd0, 3'b110, v.exp_cause});
    end
  endtask
  initial begin
    vec_t v;
    vecs[0] = '{10,   0, -1, 10,   2'b01, 2'b10, 64};
    vecs[1] = '{-1,   0, -1, 1000, 2'b10, 2'b10, 64};
    vecs[2] = '{1000, 0, -1, 1000, 2'b01, 2'b10, 64};
    vecs[3] = '{0,    0, -1, 0,    2'b01, 2'b01, 64};
    vecs[4] = '{5,    3, -1, 5,    2'b01, 2'b10, 95};
    vecs[5] = '{3,    0, 12, 3,    2'b01, 2'b10, -1};
    vecs[6] = '{-1,   1, -1, 1000, 2'b10, 2'b10, -1};
    vecs[7] = '{1001, 1, -1, 1000, 2'b10, 2'b10, -1};
    vecs[8] = '{999,  3, -1, 999,  2'b01, 2'b10, 95};
    for (int i = 0; i < 9; i++) run(vecs[i]);
    for (int r = 0; r < 4; r++) begin
      v.pc_cyc     = int'($urandom_range(0, 1200));
      v.rdy_mode   = 1;
      v.abort      = -1;
      v.exp_trig   = v.pc_cyc <= MAXC ? v.pc_cyc : MAXC;
      v.exp_cause  = v.pc_cyc <= MAXC ? 2'b01 : 2'b10;
      v.exp_cause0 = v.pc_cyc == 0 ? 2'b01 : 2'b10;
      v.exp_dump   = -1;
      run(v);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
